// File: rtl/debug_uart_scheduler.sv
// Round-robin change reporter: streams HEADER/ID/value frames to a byte UART.
// Define DEBUG_UART_CHECKSUM_EN for a 4th checksum byte (header ^ id ^ value).
module debug_uart_scheduler #(
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000,
  parameter logic [23:0] REFRESH_CYC = 24'd0
) (
  input  logic        clk_uart,
  input  logic        rstn,
  input  logic [7:0]  statedeb_main,
  input  logic [7:0]  statedeb_can,
  input  logic [7:0]  statedb_can_mux,
  input  logic [7:0]  statedeb_osc_trim,
  input  logic [7:0]  statedeb_elink_tra,
  input  logic [7:0]  statedeb_elink_rec,
  input  logic [7:0]  statedeb_spi,
  input  logic        in_rx_dv,
  input  logic [7:0]  in_rx_byte,
  output logic        out_tx_dv,
  output logic [7:0]  out_tx_byte,
  input  logic        in_tx_done,
  output logic        out_busy,
  output logic        out_frozen,
  output logic        out_tx_err,
  output logic        out_cmd_err,
  output logic [15:0] out_frame_cnt
);

`ifdef DEBUG_UART_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {
    IDLE, LATCH, ISSUE, WAIT
  } state_t;

  state_t      state;
  logic [7:0]  src [7];
  logic [7:0]  shadow [7];
  logic [6:0]  frc;
  logic [6:0]  frc_clr;
  logic [6:0]  frc_set;
  logic [6:0]  pending;
  logic [2:0]  last_served;
  logic [2:0]  win_id;
  logic [2:0]  pick;
  logic [3:0]  j;
  logic        any_pend;
  logic [7:0]  snap;
  logic [1:0]  idx;
  logic [15:0] tcnt;
  logic [23:0] rcnt;
  logic        refresh_hit;
  logic        cmd_dump;
  logic        tmo;

  assign src[0] = statedeb_main;
  assign src[1] = statedeb_can;
  assign src[2] = statedb_can_mux;
  assign src[3] = statedeb_osc_trim;
  assign src[4] = statedeb_elink_tra;
  assign src[5] = statedeb_elink_rec;
  assign src[6] = statedeb_spi;

  function automatic logic [7:0] frame_byte(
    input logic [1:0] i,
    input logic [2:0] id,
    input logic [7:0] val
  );
    logic [7:0] b;
    case (i)
      2'd1:    b = {5'd0, id};
      2'd2:    b = val;
`ifdef DEBUG_UART_CHECKSUM_EN
      2'd3:    b = HEADER_BYTE ^ {5'd0, id} ^ val;
`endif
      default: b = HEADER_BYTE;
    endcase
    return b;
  endfunction

  always_comb begin
    for (int i = 0; i < 7; i++)
      pending[i] = (src[i] != shadow[i]) | frc[i];
  end

  // Walk offsets from farthest to nearest so the nearest pending wins.
  always_comb begin
    pick = last_served;
    j    = '0;
    for (int i = 7; i >= 1; i--) begin
      j = {1'b0, last_served} + 4'(i);
      if (j >= 4'd7)
        j = j - 4'd7;
      if (pending[j[2:0]])
        pick = j[2:0];
    end
  end

  assign any_pend    = |pending;
  assign cmd_dump    = in_rx_dv && (in_rx_byte == 8'h01);
  assign refresh_hit = (REFRESH_CYC != 24'd0)
                    && (rcnt == REFRESH_CYC - 24'd1);
  assign tmo = (state == WAIT) && !in_tx_done
            && (tcnt == TIMEOUT_CYC - 16'd1);

  always_comb begin
    frc_clr = '0;
    frc_set = '0;
    if (state == LATCH)
      frc_clr[win_id] = 1'b1;
    if (tmo)
      frc_set[win_id] = 1'b1;
    if (cmd_dump || refresh_hit)
      frc_set = '1;
  end

  always_ff @(posedge clk_uart or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      frc           <= '1;
      last_served   <= 3'd6;
      win_id        <= '0;
      snap          <= '0;
      idx           <= '0;
      tcnt          <= '0;
      rcnt          <= '0;
      out_tx_dv     <= 1'b0;
      out_tx_byte   <= '0;
      out_busy      <= 1'b0;
      out_frozen    <= 1'b0;
      out_tx_err    <= 1'b0;
      out_cmd_err   <= 1'b0;
      out_frame_cnt <= '0;
      for (int i = 0; i < 7; i++)
        shadow[i] <= '0;
    end else begin
      out_tx_dv   <= 1'b0;
      out_tx_err  <= 1'b0;
      out_cmd_err <= 1'b0;
      frc         <= (frc & ~frc_clr) | frc_set;

      if (REFRESH_CYC != 24'd0)
        rcnt <= refresh_hit ? 24'd0 : rcnt + 24'd1;

      if (in_rx_dv) begin
        unique case (in_rx_byte)
          8'h01:   ;
          8'h02:   out_frozen  <= 1'b1;
          8'h03:   out_frozen  <= 1'b0;
          default: out_cmd_err <= 1'b1;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (any_pend && !out_frozen) begin
            win_id   <= pick;
            out_busy <= 1'b1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          snap           <= src[win_id];
          shadow[win_id] <= src[win_id];
          last_served    <= win_id;
          idx            <= '0;
          tcnt           <= '0;
          out_tx_dv      <= 1'b1;
          out_tx_byte    <= HEADER_BYTE;
          state          <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= tcnt + 16'd1;
          state <= WAIT;
        end
        WAIT: begin
          if (in_tx_done) begin
            if (idx == LAST_IDX) begin
              out_busy      <= 1'b0;
              out_frame_cnt <= out_frame_cnt + 16'd1;
              state         <= IDLE;
            end else begin
              idx         <= idx + 2'd1;
              tcnt        <= '0;
              out_tx_dv   <= 1'b1;
              out_tx_byte <= frame_byte(idx + 2'd1, win_id, snap);
              state       <= ISSUE;
            end
          end else if (tmo) begin
            out_busy   <= 1'b0;
            out_tx_err <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
